video_timing_gen: RTL and testbench

//   Parametrised raster timing generator for core video pipelines: pixel-enable divider, H/V counters,

---
 rtl/video_timing_if.sv | 30 +++
 rtl/video_timing_gen.sv | 119 +++++++++++
 tb/tb_video_timing_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster timing bundle: mode selects toward the generator, pixel enable,
// counters and sync/blank decode back to the pixel pipeline.
interface video_timing_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          pal;
    logic          scandouble;
    logic          ce_pix;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          line_rep;
    logic          HBlank;
    logic          VBlank;
    logic          HSync;
    logic          VSync;
    logic          frame_start;

    modport master (
        input  pal, scandouble,
        output ce_pix, hcount, vcount, line_rep,
               HBlank, VBlank, HSync, VSync, frame_start
    );

    modport slave (
        output pal, scandouble,
        input  ce_pix, hcount, vcount, line_rep,
               HBlank, VBlank, HSync, VSync, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable divider, H/V counters with optional
// line doubling, and registered sync/blank decode. Mode changes land only at frame end.
module video_timing_gen #(
    parameter int CE_DIV    = 4,
    parameter int H_ACTIVE  = 320,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 32,
    parameter int H_BP      = 32,
    parameter int V_ACTIVE  = 240,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 16,
    parameter int PAL_EXTRA = 50
) (
    input  logic           clk,
    input  logic           reset_n,
    video_timing_if.master vt
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_NTSC = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL_PAL  = V_TOTAL_NTSC + PAL_EXTRA;
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL_PAL);
    localparam int DW           = $clog2(CE_DIV);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VN_LAST = VW'(V_TOTAL_NTSC - 1);
    localparam logic [VW-1:0] VP_LAST = VW'(V_TOTAL_PAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DL_15K  = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DL_31K  = DW'(CE_DIV / 2 - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          ce_q, ce_d;
    logic          rep_q, rep_d;
    logic          pal_q, pal_d;
    logic          sd_q, sd_d;
    logic          hb_q, vb_q, hs_q, vs_q, fs_q;
    logic          line_adv, frame_end;
    logic [VW-1:0] v_last;
    logic [DW-1:0] dl_cur, dl_nxt;

    always_comb begin
        v_last    = pal_q ? VP_LAST : VN_LAST;
        dl_cur    = sd_q ? DL_31K : DL_15K;
        line_adv  = ce_q && (hcount_q == H_LAST);
        // In doubling mode the frame only ends after the repeat of the last line.
        frame_end = line_adv && (vcount_q == v_last) && (!sd_q || rep_q);

        pal_d = frame_end ? vt.pal        : pal_q;
        sd_d  = frame_end ? vt.scandouble : sd_q;
        dl_nxt = sd_d ? DL_31K : DL_15K;

        div_d = (frame_end || div_q == dl_cur) ? '0 : div_q + 1'b1;
        ce_d  = (div_d == dl_nxt);

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        rep_d    = rep_q;
        if (ce_q)
            hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
        if (line_adv) begin
            if (sd_q)
                rep_d = ~rep_q;
            if (!sd_q || rep_q)
                vcount_d = (vcount_q == v_last) ? '0 : vcount_q + 1'b1;
        end
        if (frame_end)
            rep_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= '0;
            ce_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            rep_q    <= 1'b0;
            pal_q    <= 1'b0;
            sd_q     <= 1'b0;
            hb_q     <= 1'b0;
            vb_q     <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            ce_q     <= ce_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            rep_q    <= rep_d;
            pal_q    <= pal_d;
            sd_q     <= sd_d;
            // Decoded from next-state counters so the flags line up with hcount/vcount.
            hb_q     <= (hcount_d >= H_ACT);
            vb_q     <= (vcount_d >= V_ACT);
            hs_q     <= (hcount_d >= HS_BEG) && (hcount_d < HS_END);
            vs_q     <= (vcount_d >= VS_BEG) && (vcount_d < VS_END);
            fs_q     <= frame_end;
        end
    end

    assign vt.ce_pix      = ce_q;
    assign vt.hcount      = hcount_q;
    assign vt.vcount      = vcount_q;
    assign vt.line_rep    = rep_q;
    assign vt.HBlank      = hb_q;
    assign vt.VBlank      = vb_q;
    assign vt.HSync       = hs_q;
    assign vt.VSync       = vs_q;
    assign vt.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: a frame-level raster model queues every expected pixel;
// a monitor pops one entry per ce_pix and checks counters, decode, pixel period and frame_start.
module tb_video_timing_gen;
    localparam int CE_DIV    = 4;
    localparam int H_ACTIVE  = 8;
    localparam int H_FP      = 2;
    localparam int H_SYNC    = 3;
    localparam int H_BP      = 3;
    localparam int V_ACTIVE  = 6;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 2;
    localparam int PAL_EXTRA = 4;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_NTSC    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_PAL     = V_NTSC + PAL_EXTRA;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_PAL);

    logic clk = 1'b0;
    logic reset_n;

    video_timing_if #(.HW(HW), .VW(VW)) vif ();

    video_timing_gen #(
        .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .PAL_EXTRA(PAL_EXTRA)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .vt     (vif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int rep;
        bit hb;
        bit vb;
        bit hs;
        bit vs;
        int fs;
        int d;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   npix  = 0;

    // Expected raster of one whole frame in the given mode.
    task automatic push_frame(input bit p, input bit s, input bit first);
        exp_t e;
        int   vt   = p ? V_PAL : V_NTSC;
        int   reps = s ? 2 : 1;
        for (int v = 0; v < vt; v++)
            for (int r = 0; r < reps; r++)
                for (int h = 0; h < H_TOTAL; h++) begin
                    e.h   = h;
                    e.v   = v;
                    e.rep = r;
                    e.hb  = (h >= H_ACTIVE);
                    e.vb  = (v >= V_ACTIVE);
                    e.hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
                    e.vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
                    e.fs  = (v == 0 && r == 0 && h == 0 && !first) ? 1 : 0;
                    e.d   = s ? CE_DIV / 2 : CE_DIV;
                    q.push_back(e);
                end
    endtask

    // Drives one frame's worth of clock edges. Mode inputs wander randomly and
    // only settle on the next-frame target for the final edge of the frame.
    task automatic run_frame(input bit p, input bit s, input bit first,
                             input bit np, input bit ns, input int abort_at);
        int len = (p ? V_PAL : V_NTSC) * H_TOTAL * CE_DIV;
        int n   = (abort_at > 0) ? abort_at : len;
        push_frame(p, s, first);
        for (int e = 1; e <= n; e++) begin
            @(negedge clk);
            if (e == len) begin
                vif.pal        = np;
                vif.scandouble = ns;
            end else begin
                vif.pal        = 1'($urandom_range(0, 1));
                vif.scandouble = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
        end
    endtask

    task automatic check_zero(input string name);
        logic [HW+VW+6:0] outs;
        outs = {vif.ce_pix, vif.hcount, vif.vcount, vif.line_rep, vif.HBlank,
                vif.VBlank, vif.HSync, vif.VSync, vif.frame_start};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL %s: outputs=%b required all zero", name, outs);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        int   gap = 0;
        int   fsc = 0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                gap = 0;
                fsc = 0;
            end else begin
                gap++;
                if (vif.frame_start) fsc++;
                if (vif.ce_pix) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_ce: h=%0d v=%0d with no pixel expected",
                                 vif.hcount, vif.vcount);
                    end else begin
                        e = q.pop_front();
                        npix++;
                        if (int'(vif.hcount) != e.h || int'(vif.vcount) != e.v ||
                            int'(vif.line_rep) != e.rep || vif.HBlank != e.hb ||
                            vif.VBlank != e.vb || vif.HSync != e.hs || vif.VSync != e.vs) begin
                            fails++;
                            $display("FAIL pixel#%0d: got h=%0d v=%0d rep=%0d hb/vb/hs/vs=%b%b%b%b, required h=%0d v=%0d rep=%0d hb/vb/hs/vs=%b%b%b%b",
                                     npix, vif.hcount, vif.vcount, vif.line_rep, vif.HBlank,
                                     vif.VBlank, vif.HSync, vif.VSync, e.h, e.v, e.rep,
                                     e.hb, e.vb, e.hs, e.vs);
                        end
                        tests++;
                        if (gap != e.d) begin
                            fails++;
                            $display("FAIL ce_period pixel#%0d (h=%0d v=%0d): got %0d clk, required %0d",
                                     npix, e.h, e.v, gap, e.d);
                        end
                        tests++;
                        if (fsc != e.fs) begin
                            fails++;
                            $display("FAIL frame_start pixel#%0d (h=%0d v=%0d): got %0d pulses, required %0d",
                                     npix, e.h, e.v, fsc, e.fs);
                        end
                    end
                    gap = 0;
                    fsc = 0;
                end else if (gap > 2 * CE_DIV) begin
                    tests++;
                    fails++;
                    $display("FAIL ce_timeout: no ce_pix for %0d clk", gap);
                    gap = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit [1:0] tgt[4];
        bit [1:0] nx;
        bit       cp;
        bit       cs;
        tgt[0] = 2'b10;
        tgt[1] = 2'b11;
        tgt[2] = 2'b01;
        tgt[3] = 2'b00;

        reset_n        = 1'b1;
        vif.pal        = 1'b0;
        vif.scandouble = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_zero("reset_init");
        vif.pal        = 1'b1;
        vif.scandouble = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // First frame is always NTSC/15 kHz; later frames take the settled inputs.
        cp = 1'b0;
        cs = 1'b0;
        for (int k = 0; k < 7; k++) begin
            nx = (k < 4) ? tgt[k] : 2'($urandom_range(0, 3));
            run_frame(cp, cs, k == 0, nx[1], nx[0], 0);
            cp = nx[1];
            cs = nx[0];
        end

        // Reset in the middle of a frame, inputs requesting PAL+scandouble meanwhile.
        run_frame(cp, cs, 1'b0, 1'b0, 1'b0,
                  ((cp ? V_PAL : V_NTSC) * H_TOTAL * CE_DIV) / 2 + int'($urandom_range(0, 7)));
        #2 reset_n = 1'b0;
        #1 check_zero("reset_mid");
        q.delete();
        vif.pal        = 1'b1;
        vif.scandouble = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected pixels never presented, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
